// File: rtl/tl_handshake_assert_monitor.sv
// Passive valid/ready protocol checker for N_CH request channels.
// It checks handshake exclusivity, payload stability, stall timeout and outstanding accounting, and keeps sticky first-error capture registers.
module tl_handshake_assert_monitor #(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned TIMEOUT  = 256,
  parameter int unsigned MAX_OUT  = 15,
  parameter bit          FATAL_EN = 1'b1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_CH-1:0]          in_valid,
  input  logic [N_CH-1:0]          in_ready,
  input  logic [N_CH*DATA_W-1:0]   in_bits,
  input  logic                     resp_fire,
  input  logic                     err_clear,
  output logic                     err_sticky,
  output logic [2:0]               err_code,
  output logic [3:0]               err_chan,
  output logic [7:0]               err_count,
  output logic [7:0]               outstanding
);

  localparam int unsigned CODE_W = 3;
  localparam int unsigned CHAN_W = 4;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned OUT_W  = 8;
  localparam int unsigned TMO_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [CODE_W-1:0] E_MUTEX = 3'd1;
  localparam logic [CODE_W-1:0] E_DROP  = 3'd2;
  localparam logic [CODE_W-1:0] E_BITS  = 3'd3;
  localparam logic [CODE_W-1:0] E_TMO   = 3'd4;
  localparam logic [CODE_W-1:0] E_OVF   = 3'd5;
  localparam logic [CODE_W-1:0] E_UNF   = 3'd6;

  logic [N_CH-1:0]   stalled_q, stalled_d;
  logic [DATA_W-1:0] bits_q [N_CH];
  logic [DATA_W-1:0] bits_d [N_CH];
  logic [TMO_W-1:0]  stall_cnt_q [N_CH];
  logic [TMO_W-1:0]  stall_cnt_d [N_CH];
  logic [OUT_W-1:0]  out_q, out_d;
  logic              sticky_q, sticky_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [CHAN_W-1:0] chan_q, chan_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              armed_q;

  logic [N_CH-1:0]   fire_c, stall_c, drop_c, chg_c, tmo_c;
  logic              any_fire_c, mutex_c, ovf_c, unf_c, err_c;
  logic [CHAN_W-1:0] first_fire_c, chan_c;
  logic [CODE_W-1:0] code_c;

  function automatic logic [CHAN_W-1:0] lowest_idx(input logic [N_CH-1:0] v);
    lowest_idx = '0;
    for (int i = int'(N_CH) - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = CHAN_W'(i);
    end
  endfunction

  // Violation detection; the lowest code wins, then the lowest channel
  always_comb begin
    fire_c  = in_valid & in_ready;
    stall_c = in_valid & ~in_ready;
    drop_c  = '0;
    chg_c   = '0;
    tmo_c   = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      drop_c[i] = stalled_q[i] & ~in_valid[i];
      chg_c[i]  = stalled_q[i] & in_valid[i] &
                  (in_bits[i*DATA_W +: DATA_W] != bits_q[i]);
      tmo_c[i]  = (TIMEOUT != 0) && stall_c[i] &&
                  (stall_cnt_q[i] == TMO_W'(TIMEOUT - 1));
    end
    any_fire_c   = |fire_c;
    mutex_c      = (fire_c & (fire_c - N_CH'(1))) != '0;
    first_fire_c = lowest_idx(fire_c);
    ovf_c        = any_fire_c & ~resp_fire & (out_q == OUT_W'(MAX_OUT));
    unf_c        = resp_fire & ~any_fire_c & (out_q == '0);
    code_c       = '0;
    chan_c       = '0;
    if (mutex_c) begin
      code_c = E_MUTEX;
      chan_c = first_fire_c;
    end else if (|drop_c) begin
      code_c = E_DROP;
      chan_c = lowest_idx(drop_c);
    end else if (|chg_c) begin
      code_c = E_BITS;
      chan_c = lowest_idx(chg_c);
    end else if (|tmo_c) begin
      code_c = E_TMO;
      chan_c = lowest_idx(tmo_c);
    end else if (ovf_c) begin
      code_c = E_OVF;
      chan_c = first_fire_c;
    end else if (unf_c) begin
      code_c = E_UNF;
      chan_c = first_fire_c;
    end
    // The first cycle after reset release is never flagged
    err_c = armed_q & (code_c != '0);
  end

  // Next-state for channel tracking, outstanding counter and capture
  always_comb begin
    stalled_d = stall_c;
    for (int i = 0; i < int'(N_CH); i++) begin
      bits_d[i]      = stall_c[i] ? in_bits[i*DATA_W +: DATA_W] : bits_q[i];
      stall_cnt_d[i] = '0;
      if (stall_c[i]) begin
        stall_cnt_d[i] = (stall_cnt_q[i] == TMO_W'(TIMEOUT)) ? stall_cnt_q[i]
                                                             : stall_cnt_q[i] + TMO_W'(1);
      end
    end
    out_d = out_q;
    if (any_fire_c && !resp_fire && !ovf_c) begin
      out_d = out_q + OUT_W'(1);
    end else if (resp_fire && !any_fire_c && !unf_c) begin
      out_d = out_q - OUT_W'(1);
    end
    sticky_d = sticky_q;
    code_d   = code_q;
    chan_d   = chan_q;
    count_d  = count_q;
    if (err_clear) begin
      sticky_d = 1'b0;
      code_d   = '0;
      chan_d   = '0;
      count_d  = '0;
    end
    if (err_c) begin
      if (!sticky_d) begin
        code_d = code_c;
        chan_d = chan_c;
      end
      sticky_d = 1'b1;
      count_d  = (count_d == '1) ? count_d : count_d + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stalled_q <= '0;
      for (int i = 0; i < int'(N_CH); i++) begin
        bits_q[i]      <= '0;
        stall_cnt_q[i] <= '0;
      end
      out_q    <= '0;
      sticky_q <= 1'b0;
      code_q   <= '0;
      chan_q   <= '0;
      count_q  <= '0;
      armed_q  <= 1'b0;
    end else begin
      stalled_q   <= stalled_d;
      bits_q      <= bits_d;
      stall_cnt_q <= stall_cnt_d;
      out_q       <= out_d;
      sticky_q    <= sticky_d;
      code_q      <= code_d;
      chan_q      <= chan_d;
      count_q     <= count_d;
      armed_q     <= 1'b1;
    end
  end

  assign err_sticky  = sticky_q;
  assign err_code    = code_q;
  assign err_chan    = chan_q;
  assign err_count   = count_q;
  assign outstanding = out_q;

`ifndef SYNTHESIS
  // Simulation-time report of each violating cycle
  always_ff @(posedge clock) begin
    if (!reset && err_c) begin
      $display("tl_handshake_assert_monitor: protocol violation code %0d channel %0d",
               code_c, chan_c);
      if (FATAL_EN) begin
        $fatal(1, "tl_handshake_assert_monitor: stopping on protocol violation");
      end
    end
  end
`endif

endmodule
